// File: rtl/mem_bus_unit.sv
// mem_bus_unit: arbitrates core fetch and data requests onto one shared memory port.
// Sequential instruction prefetch is compiled in when MEM_BUS_PREFETCH_EN is defined.
module mem_bus_unit #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int PREFETCH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [WORD_SIZE-1:0]  if_instr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_done,
    output logic [WORD_SIZE-1:0]  d_rdata,
    output logic                  busy,
    output logic                  readM,
    output logic                  writeM,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [WORD_SIZE-1:0]  data,
    input  logic                  inputReady,
    input  logic                  ackOutput
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DREAD  = 3'd2,
`ifdef MEM_BUS_PREFETCH_EN
        PFETCH = 3'd4,
`endif
        DWRITE = 3'd3
    } state_t;

    if (PREFETCH_DEPTH < 2 || (PREFETCH_DEPTH & (PREFETCH_DEPTH - 1)) != 0) begin : g_depth_check
        $error("PREFETCH_DEPTH must be a power of two and at least 2");
    end

    state_t                state_r;
    state_t                next_state_s;
    logic                  ld_addr_s;
    logic [ADDR_WIDTH-1:0] nxt_addr_s;
    logic                  fetch_done_s;
    logic                  load_done_s;
    logic                  store_done_s;
    logic                  pop_s;
    logic [WORD_SIZE-1:0]  hit_instr_s;
    logic [WORD_SIZE-1:0]  wdata_r;

`ifdef MEM_BUS_PREFETCH_EN
    localparam int PTR_W = $clog2(PREFETCH_DEPTH);

    logic [ADDR_WIDTH-1:0] pf_addr_r  [PREFETCH_DEPTH];
    logic [WORD_SIZE-1:0]  pf_instr_r [PREFETCH_DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [PTR_W:0]        count_r;
    logic [ADDR_WIDTH-1:0] last_addr_r;
    logic                  last_valid_r;
    logic                  pf_empty_s;
    logic                  pf_full_s;
    logic                  pf_hit_s;
    logic                  st_hit_s;
    logic                  push_s;
    logic                  flush_s;

    assign pf_empty_s  = (count_r == (PTR_W+1)'(0));
    assign pf_full_s   = (count_r == (PTR_W+1)'(PREFETCH_DEPTH));
    assign pf_hit_s    = if_req && !pf_empty_s && (pf_addr_r[head_r] == if_addr);
    assign hit_instr_s = pf_instr_r[head_r];

    // Store invalidation: match d_addr against every occupied buffer slot
    always_comb begin
        st_hit_s = 1'b0;
        for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            if (({1'b0, PTR_W'(i) - head_r} < count_r) && (pf_addr_r[i] == d_addr)) begin
                st_hit_s = 1'b1;
            end else begin
                st_hit_s = st_hit_s;
            end
        end
    end

    // Prefetch FIFO pointers and the sequential-prefetch origin; flush beats push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            last_addr_r  <= '0;
            last_valid_r <= 1'b0;
        end else begin
            if (flush_s) begin
                head_r  <= '0;
                tail_r  <= '0;
                count_r <= '0;
            end else if (push_s) begin
                tail_r  <= tail_r + PTR_W'(1);
                count_r <= count_r + (PTR_W+1)'(1);
            end else if (pop_s) begin
                head_r  <= head_r + PTR_W'(1);
                count_r <= count_r - (PTR_W+1)'(1);
            end
            if (push_s || fetch_done_s) begin
                last_addr_r  <= address;
                last_valid_r <= 1'b1;
            end
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                pf_addr_r[i]  <= '0;
                pf_instr_r[i] <= '0;
            end
        end else if (push_s && !flush_s) begin
            pf_addr_r[tail_r]  <= address;
            pf_instr_r[tail_r] <= data;
        end
    end
`else
    assign hit_instr_s = {WORD_SIZE{1'b0}};
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration and transaction sequencing; data always wins over fetch
    always_comb begin
        next_state_s = state_r;
        ld_addr_s    = 1'b0;
        nxt_addr_s   = address;
        fetch_done_s = 1'b0;
        load_done_s  = 1'b0;
        store_done_s = 1'b0;
        pop_s        = 1'b0;
`ifdef MEM_BUS_PREFETCH_EN
        push_s       = 1'b0;
        flush_s      = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (d_req) begin
                    next_state_s = d_we ? DWRITE : DREAD;
                    ld_addr_s    = 1'b1;
                    nxt_addr_s   = d_addr;
`ifdef MEM_BUS_PREFETCH_EN
                    flush_s      = d_we && st_hit_s;
`endif
                end
`ifdef MEM_BUS_PREFETCH_EN
                else if (pf_hit_s) begin
                    pop_s = 1'b1;
                end
`endif
                else if (if_req) begin
                    next_state_s = FETCH;
                    ld_addr_s    = 1'b1;
                    nxt_addr_s   = if_addr;
`ifdef MEM_BUS_PREFETCH_EN
                    flush_s      = !pf_empty_s;
`endif
                end
`ifdef MEM_BUS_PREFETCH_EN
                else if (last_valid_r && !pf_full_s) begin
                    next_state_s = PFETCH;
                    ld_addr_s    = 1'b1;
                    nxt_addr_s   = last_addr_r + ADDR_WIDTH'(1);
                end
`endif
                else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (inputReady) begin
                    next_state_s = IDLE;
                    fetch_done_s = 1'b1;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DREAD: begin
                if (inputReady) begin
                    next_state_s = IDLE;
                    load_done_s  = 1'b1;
                end else begin
                    next_state_s = DREAD;
                end
            end
            DWRITE: begin
                if (ackOutput) begin
                    next_state_s = IDLE;
                    store_done_s = 1'b1;
                end else begin
                    next_state_s = DWRITE;
                end
            end
`ifdef MEM_BUS_PREFETCH_EN
            PFETCH: begin
                if (inputReady) begin
                    next_state_s = IDLE;
                    push_s       = 1'b1;
                end else begin
                    next_state_s = PFETCH;
                end
            end
`endif
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Registered bus strobes, address and core-side results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readM    <= 1'b0;
            writeM   <= 1'b0;
            address  <= '0;
            wdata_r  <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            d_done   <= 1'b0;
            d_rdata  <= '0;
        end else begin
            readM    <= (next_state_s != IDLE) && (next_state_s != DWRITE);
            writeM   <= (next_state_s == DWRITE);
            if_valid <= fetch_done_s || pop_s;
            d_done   <= load_done_s || store_done_s;
            if (ld_addr_s) begin
                address <= nxt_addr_s;
            end
            if (state_r == IDLE && next_state_s == DWRITE) begin
                wdata_r <= d_wdata;
            end
            if (fetch_done_s) begin
                if_instr <= data;
            end else if (pop_s) begin
                if_instr <= hit_instr_s;
            end
            if (load_done_s) begin
                d_rdata <= data;
            end
        end
    end

    assign busy = (state_r != IDLE);
    assign data = writeM ? wdata_r : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit; prefetch scenarios run when MEM_BUS_PREFETCH_EN is defined.
module tb_mem_bus_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, d_req, d_we, inputReady, ackOutput;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_valid, d_done, busy, readM, writeM;
    logic [15:0] if_instr, d_rdata, address;
    wire  [15:0] data;
    logic [15:0] mem_drv;
    logic        mem_oe;
    int          total = 0;
    int          bad = 0;

    assign data = mem_oe ? mem_drv : 16'hzzzz;

    mem_bus_unit dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_instr(if_instr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .busy(busy),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (readM !== 1'b0) begin bad++; $display("FAIL rst_readM got=%b exp=0", readM); end
        total++; if (writeM !== 1'b0) begin bad++; $display("FAIL rst_writeM got=%b exp=0", writeM); end
        total++; if (address !== 16'h0000) begin bad++; $display("FAIL rst_address got=%h exp=0000", address); end
        total++; if (if_valid !== 1'b0 || d_done !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", if_valid, d_done); end
        total++; if (if_instr !== 16'h0000 || d_rdata !== 16'h0000) begin bad++; $display("FAIL rst_regs got=%h/%h exp=0000/0000", if_instr, d_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (!(data === 16'hzzzz || data === 16'h0000)) begin bad++; $display("FAIL rst_data_hiz got=%h exp=zzzz", data); end
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        tick();
        total++; if (readM !== 1'b1 || writeM !== 1'b0) begin bad++; $display("FAIL load_strobe0 got=%b%b exp=10", readM, writeM); end
        total++; if (address !== 16'h0040) begin bad++; $display("FAIL load_address got=%h exp=0040", address); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b exp=1", busy); end
        mem_drv = 16'h1234; mem_oe = 1'b1;
        tick();
        total++; if (readM !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL load_wait1 got=%b%b exp=10", readM, d_done); end
        tick();
        total++; if (readM !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL load_wait2 got=%b%b exp=10", readM, d_done); end
        inputReady = 1'b1;
        tick();
        total++; if (readM !== 1'b0) begin bad++; $display("FAIL load_readM_drop got=%b exp=0", readM); end
        total++; if (d_done !== 1'b1) begin bad++; $display("FAIL load_done got=%b exp=1", d_done); end
        total++; if (d_rdata !== 16'h1234) begin bad++; $display("FAIL load_rdata got=%h exp=1234", d_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_idle got=%b exp=0", busy); end
        d_req = 1'b0; inputReady = 1'b0; mem_oe = 1'b0;
        tick();
        total++; if (d_done !== 1'b0 || readM !== 1'b0) begin bad++; $display("FAIL load_pulse_end got=%b%b exp=00", d_done, readM); end
    endtask

    task automatic test_store();
        total++; if (!(data === 16'hzzzz || data === 16'h0000)) begin bad++; $display("FAIL st_pre_hiz got=%h exp=zzzz", data); end
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        tick();
        total++; if (writeM !== 1'b1 || readM !== 1'b0) begin bad++; $display("FAIL st_strobe0 got=%b%b exp=10", writeM, readM); end
        total++; if (address !== 16'h0010) begin bad++; $display("FAIL st_address got=%h exp=0010", address); end
        total++; if (data !== 16'hBEEF) begin bad++; $display("FAIL st_data0 got=%h exp=beef", data); end
        tick();
        total++; if (writeM !== 1'b1 || data !== 16'hBEEF) begin bad++; $display("FAIL st_data1 got=%b/%h exp=1/beef", writeM, data); end
        ackOutput = 1'b1;
        tick();
        total++; if (writeM !== 1'b0 || d_done !== 1'b1) begin bad++; $display("FAIL st_done got=%b%b exp=01", writeM, d_done); end
        total++; if (!(data === 16'hzzzz || data === 16'h0000)) begin bad++; $display("FAIL st_post_hiz got=%h exp=zzzz", data); end
        total++; if (d_rdata !== 16'h1234) begin bad++; $display("FAIL st_rdata_hold got=%h exp=1234", d_rdata); end
        d_req = 1'b0; d_we = 1'b0; ackOutput = 1'b0;
        tick();
        total++; if (d_done !== 1'b0) begin bad++; $display("FAIL st_pulse_end got=%b exp=0", d_done); end
    endtask

    task automatic test_ignored_response();
        inputReady = 1'b1; ackOutput = 1'b1;
        tick();
        total++; if (d_done !== 1'b0 || if_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stray_resp got=%b%b%b exp=000", d_done, if_valid, busy); end
        inputReady = 1'b0; ackOutput = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        tick();
        total++; if (address !== 16'h0200 || readM !== 1'b1) begin bad++; $display("FAIL arb_data_first got=%h/%b exp=0200/1", address, readM); end
        mem_drv = 16'h5555; mem_oe = 1'b1; inputReady = 1'b1;
        tick();
        total++; if (d_done !== 1'b1 || d_rdata !== 16'h5555 || if_valid !== 1'b0) begin bad++; $display("FAIL arb_data_done got=%b/%h/%b exp=1/5555/0", d_done, d_rdata, if_valid); end
        d_req = 1'b0; inputReady = 1'b0;
        tick();
        total++; if (address !== 16'h0100 || readM !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL arb_fetch_start got=%h/%b/%b exp=0100/1/0", address, readM, d_done); end
        mem_drv = 16'hA5A5; inputReady = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_instr !== 16'hA5A5 || readM !== 1'b0) begin bad++; $display("FAIL arb_fetch_done got=%b/%h/%b exp=1/a5a5/0", if_valid, if_instr, readM); end
        if_req = 1'b0; inputReady = 1'b0; mem_oe = 1'b0;
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL arb_pulse_end got=%b exp=0", if_valid); end
`ifndef MEM_BUS_PREFETCH_EN
        total++; if (readM !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arb_bus_idle got=%b%b exp=00", readM, busy); end
`endif
    endtask

    task automatic test_reset_mid_read();
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        tick();
        total++; if (readM !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rmid_active got=%b%b exp=11", readM, busy); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (readM !== 1'b0 || busy !== 1'b0 || address !== 16'h0000) begin bad++; $display("FAIL rmid_async got=%b%b/%h exp=00/0000", readM, busy, address); end
        d_req = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        total++; if (readM !== 1'b0) begin bad++; $display("FAIL rmid_after got=%b exp=0", readM); end
        d_req = 1'b1; d_addr = 16'h0400;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0400) begin bad++; $display("FAIL rmid_fresh got=%b/%h exp=1/0400", readM, address); end
        mem_drv = 16'h4444; mem_oe = 1'b1; inputReady = 1'b1;
        tick();
        total++; if (d_done !== 1'b1 || d_rdata !== 16'h4444 || readM !== 1'b0) begin bad++; $display("FAIL rmid_fresh_done got=%b/%h/%b exp=1/4444/0", d_done, d_rdata, readM); end
        d_req = 1'b0; inputReady = 1'b0; mem_oe = 1'b0;
        tick();
    endtask

`ifdef MEM_BUS_PREFETCH_EN
    task automatic test_prefetch();
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        if_req = 1'b1; if_addr = 16'h0005;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0005) begin bad++; $display("FAIL pf_fetch got=%b/%h exp=1/0005", readM, address); end
        mem_drv = 16'h1005; mem_oe = 1'b1; inputReady = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_instr !== 16'h1005) begin bad++; $display("FAIL pf_fetch_done got=%b/%h exp=1/1005", if_valid, if_instr); end
        if_req = 1'b0; inputReady = 1'b0;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0006) begin bad++; $display("FAIL pf_first got=%b/%h exp=1/0006", readM, address); end
        mem_drv = 16'h1006; inputReady = 1'b1;
        tick();
        inputReady = 1'b0;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0007) begin bad++; $display("FAIL pf_second got=%b/%h exp=1/0007", readM, address); end
        mem_drv = 16'h1007; inputReady = 1'b1;
        tick();
        inputReady = 1'b0;
        tick();
        total++; if (readM !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL pf_full_idle got=%b%b exp=00", readM, busy); end
        if_req = 1'b1; if_addr = 16'h0006;
        tick();
        total++; if (if_valid !== 1'b1 || if_instr !== 16'h1006 || readM !== 1'b0) begin bad++; $display("FAIL pf_hit got=%b/%h/%b exp=1/1006/0", if_valid, if_instr, readM); end
        if_req = 1'b0;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0008) begin bad++; $display("FAIL pf_refill got=%b/%h exp=1/0008", readM, address); end
        mem_drv = 16'h1008; inputReady = 1'b1;
        tick();
        inputReady = 1'b0; if_req = 1'b1; if_addr = 16'h0020;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0020 || if_valid !== 1'b0) begin bad++; $display("FAIL pf_miss got=%b/%h/%b exp=1/0020/0", readM, address, if_valid); end
        mem_drv = 16'h2020; inputReady = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_instr !== 16'h2020) begin bad++; $display("FAIL pf_miss_done got=%b/%h exp=1/2020", if_valid, if_instr); end
        if_req = 1'b0; inputReady = 1'b0; mem_oe = 1'b0;
    endtask

    task automatic test_wrap_invalidate();
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        if_req = 1'b1; if_addr = 16'hFFFF;
        tick();
        mem_drv = 16'h7FFF; mem_oe = 1'b1; inputReady = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_instr !== 16'h7FFF) begin bad++; $display("FAIL wrap_fetch got=%b/%h exp=1/7fff", if_valid, if_instr); end
        if_req = 1'b0; inputReady = 1'b0;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0000) begin bad++; $display("FAIL wrap_addr got=%b/%h exp=1/0000", readM, address); end
        mem_drv = 16'h7000; inputReady = 1'b1;
        tick();
        inputReady = 1'b0;
        tick();
        mem_drv = 16'h7001; inputReady = 1'b1;
        tick();
        inputReady = 1'b0; mem_oe = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0000; d_wdata = 16'hCAFE;
        tick();
        total++; if (writeM !== 1'b1 || data !== 16'hCAFE) begin bad++; $display("FAIL wrap_store got=%b/%h exp=1/cafe", writeM, data); end
        ackOutput = 1'b1;
        tick();
        d_req = 1'b0; d_we = 1'b0; ackOutput = 1'b0;
        if_req = 1'b1; if_addr = 16'h0000;
        tick();
        total++; if (readM !== 1'b1 || address !== 16'h0000 || if_valid !== 1'b0) begin bad++; $display("FAIL wrap_inval got=%b/%h/%b exp=1/0000/0", readM, address, if_valid); end
        mem_drv = 16'h7000; mem_oe = 1'b1; inputReady = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_instr !== 16'h7000) begin bad++; $display("FAIL wrap_refetch got=%b/%h exp=1/7000", if_valid, if_instr); end
        if_req = 1'b0; inputReady = 1'b0; mem_oe = 1'b0;
    endtask
`endif

    initial begin
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; inputReady = 1'b0; ackOutput = 1'b0;
        if_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        mem_drv = 16'h0000; mem_oe = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_ignored_response();
        test_arbitration();
        test_reset_mid_read();
`ifdef MEM_BUS_PREFETCH_EN
        test_prefetch();
        test_wrap_invalidate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_bus_unit.md
# mem_bus_unit

Parametrised memory bus interface unit for the multi-cycle CPU. It arbitrates instruction fetches and data loads/stores from the core onto the single shared memory port (readM / writeM / address / data, with inputReady / ackOutput handshakes). It converts the level-held core requests into properly sequenced bus transactions, and can optionally run sequential instruction prefetch into a small buffer. It sits between the control/datapath and the external memory, replacing the ad-hoc clock-phase bus muxing.

## Interface
- WORD_SIZE, 16, data/instruction width
- ADDR_WIDTH, 16, address width
- PREFETCH_DEPTH, 2, prefetch buffer entries (power of two, ≥2; used only with prefetch compiled in)

- clk  input  1  clock, rising-edge
- reset_n  input  1  reset; asynchronous, active-low
- if_req  input  1  fetch request, held until if_valid
- if_addr  input  ADDR_WIDTH  fetch address
- if_valid  output  1  one-cycle pulse, if_instr valid
- if_instr  output  WORD_SIZE  fetched instruction
- d_req  input  1  data request, held until d_done
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  WORD_SIZE  store data
- d_done  output  1  one-cycle pulse, access complete
- d_rdata  output  WORD_SIZE  load data, valid with d_done, held until next load
- busy  output  1  FSM not IDLE
- readM  output  1  memory read strobe
- writeM  output  1  memory write strobe
- address  output  ADDR_WIDTH  memory address, registered
- data  inout  WORD_SIZE  bus; driven only in DWRITE, else high-Z
- inputReady  input  1  memory read data valid
- ackOutput  input  1  memory write accepted

## Operation
- FSM states: IDLE, FETCH, DREAD, DWRITE, PFETCH (PFETCH exists only with prefetch).
- IDLE arbitration at each edge, first match wins:
  - d_req: go to DWRITE if d_we, else DREAD.
  - if_req, prefetch hit: served from the buffer.
  - if_req: go to FETCH.
  - Prefetch condition met: go to PFETCH.
  - Data always beats fetch.
- On entry to a bus state: address ← request address; readM=1 (FETCH/DREAD/PFETCH) or writeM=1 (DWRITE).
- Read states wait for inputReady sampled high. Then:
  - data is captured;
  - readM drops;
  - the matching pulse fires: if_valid (FETCH), d_done (DREAD), or a buffer push (PFETCH);
  - the FSM returns to IDLE.
- DWRITE drives data=d_wdata and waits for ackOutput sampled high. Then writeM drops, d_done pulses, and the FSM returns to IDLE.
- A transaction in progress is never aborted except by reset.
- Never more than one of readM/writeM is high.
- Reset (async): readM=writeM=0, address=0, if_valid=d_done=0, if_instr=d_rdata=0, busy=0, data high-Z, buffer empty, state IDLE.

## Timing
- Request sampled at edge E. The strobe is high from just after E.
- Response (inputReady/ackOutput) is sampled high at edge E+k, k≥1. The pulse is high for cycle E+k..E+k+1, the strobe is low from E+k, and the FSM is back in IDLE at E+k.
- Next request is accepted at E+k+1. Minimum bus latency is 2 cycles.
- Prefetch hit: if_req sampled at E gives if_valid in cycle E..E+1. Latency is 1 cycle.
- A response asserted while no strobe is active is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH: prefetch after 0xFFFF targets 0x0000.

## Configuration
- MEM_BUS_PREFETCH_EN defined:
  - Buffer: PREFETCH_DEPTH entries of {addr, instr}, stored as a circular FIFO.
  - Prefetch condition: IDLE, no request, buffer not full. Target = last fetched/prefetched address + 1.
  - Hit: if_addr equals the head entry's addr. Deliver it and pop.
  - Miss (if_req with buffer non-empty and no head match): flush the buffer, then run a normal FETCH.
  - A store to an address present in the buffer flushes the whole buffer when the store is accepted.
  - A push and a flush in the same cycle: the flush wins.
- MEM_BUS_PREFETCH_EN undefined:
  - No buffer and no PFETCH state.
  - Every fetch is a bus FETCH.
  - The bus is idle when there are no requests.
  - PREFETCH_DEPTH is ignored.

## Test plan
- Load with memory latency k=3: d_req, d_addr=0x0040, inputReady on the 3rd edge, data=0x1234 → readM high 3 cycles, address=0x0040, d_done one cycle, d_rdata=0x1234.
- Store: d_we=1, d_addr=0x0010, d_wdata=0xBEEF, ackOutput after 2 edges → writeM high 2 cycles, data=0xBEEF only during DWRITE, high-Z otherwise, d_done pulse.
- if_req and d_req raised in the same cycle → data transaction runs first, fetch starts at the edge after d_done, if_valid follows.
- Prefetch (EN): fetch 0x0005 → buffer fills with 0x0006 and 0x0007 → if_req 0x0006 gives if_valid next cycle with no readM; if_req 0x0020 flushes the buffer and performs a bus fetch.
- Wrap and invalidate (EN):
  - Fetch 0xFFFF → prefetch address=0x0000.
  - A store to 0x0000 flushes the buffer.
  - The next if_req 0x0000 goes to the bus.
- Reset asserted mid-DREAD (readM=1) → readM=0 and busy=0 immediately without a clock; after release, a fresh load completes normally.
